// File: rtl/mult_radix4_seq.sv
`default_nettype none
// ============================================================================
// Module   : mult_radix4_seq
// Purpose  : Iterative unsigned WIDTH x WIDTH multiplier. One 2-bit digit of
//            B is retired per cycle: the digit is multiplied against every
//            2-bit digit of A with 2x2 -> 4-bit sub-products, the sub-products
//            are summed into a WIDTH+2 bit row, and the row is shifted into a
//            2*WIDTH bit accumulator. Operands enter and the product leaves
//            through valid/ready handshakes.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            in_valid   - A/B valid
//            in_ready   - operands accepted (high only in IDLE)
//            A, B       - unsigned operands, WIDTH bits
//            out_valid  - P holds a completed product
//            out_ready  - consumer accepts P
//            P          - registered product, 2*WIDTH bits
//            busy       - high while running or holding a result
// Revision : 1.0 - initial release
// ============================================================================
module mult_radix4_seq #(
  parameter int WIDTH      = 8,
  parameter int EARLY_TERM = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  localparam int N    = WIDTH / 2;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int PW   = 2 * WIDTH;
  localparam int ROWW = WIDTH + 2;
  localparam int SW   = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_p;
  logic              r_ov;
  logic [KW-1:0]     r_k;

  logic [SW-1:0]     w_base;      // 2*k: bit position of the current B digit
  logic [1:0]        w_digit;
  logic [3:0]        w_pp [N];
  logic [ROWW-1:0]   w_row;
  logic [PW-1:0]     w_row_sh;
  logic [PW-1:0]     w_acc_nxt;
  logic              w_last;
  logic              w_hi_zero;
  logic              w_finish;

  assign w_base  = SW'(r_k) << 1;
  assign w_digit = 2'(r_b >> w_base);

  // 2x2 digit products of every A digit against the current B digit.
  for (genvar j = 0; j < N; j++) begin : g_pp
    assign w_pp[j] = 4'(r_a[2*j +: 2]) * 4'(w_digit);
  end

  // Row = sum of sub-products weighted by their A digit position.
  always_comb begin
    w_row = '0;
    for (int j = 0; j < N; j++) begin
      w_row = w_row + (ROWW'(w_pp[j]) << (2 * j));
    end
  end

  assign w_row_sh  = PW'(w_row) << w_base;
  assign w_acc_nxt = r_acc + w_row_sh;

  assign w_last    = (r_k == KW'(N - 1));
  // Digits above the current one are all zero, so later rows would add 0.
  assign w_hi_zero = ((r_b >> (w_base + SW'(2))) == '0);
  assign w_finish  = w_last || ((EARLY_TERM != 0) && w_hi_zero);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:  if (w_finish)  w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_p   <= '0;
      r_ov  <= 1'b0;
      r_k   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= A;
            r_b   <= B;
            r_acc <= '0;
            r_k   <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + KW'(1);
          if (w_finish) begin
            r_p  <= w_acc_nxt;
            r_ov <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_ov <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_ov;
  assign P         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_mult_radix4_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_radix4_seq
// Purpose  : Self-checking bench for mult_radix4_seq. Four instances cover
//            WIDTH=8 (plain and early-terminating), WIDTH=16 plain and
//            WIDTH=32 early-terminating. Products and latencies are predicted
//            from plain arithmetic on the operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_radix4_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv_s [4];
  logic        or_s [4];
  logic [31:0] a_s  [4];
  logic [31:0] b_s  [4];
  wire  [3:0]  ov_s;
  wire  [3:0]  ir_s;
  wire  [3:0]  bz_s;
  wire  [15:0] p0;
  wire  [15:0] p1;
  wire  [31:0] p2;
  wire  [63:0] p3;

  int tests  = 0;
  int failed = 0;

  mult_radix4_seq #(.WIDTH(8), .EARLY_TERM(0)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv_s[0]), .in_ready(ir_s[0]),
    .A(a_s[0][7:0]), .B(b_s[0][7:0]), .out_valid(ov_s[0]),
    .out_ready(or_s[0]), .P(p0), .busy(bz_s[0]));

  mult_radix4_seq #(.WIDTH(8), .EARLY_TERM(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv_s[1]), .in_ready(ir_s[1]),
    .A(a_s[1][7:0]), .B(b_s[1][7:0]), .out_valid(ov_s[1]),
    .out_ready(or_s[1]), .P(p1), .busy(bz_s[1]));

  mult_radix4_seq #(.WIDTH(16), .EARLY_TERM(0)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(iv_s[2]), .in_ready(ir_s[2]),
    .A(a_s[2][15:0]), .B(b_s[2][15:0]), .out_valid(ov_s[2]),
    .out_ready(or_s[2]), .P(p2), .busy(bz_s[2]));

  mult_radix4_seq #(.WIDTH(32), .EARLY_TERM(1)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(iv_s[3]), .in_ready(ir_s[3]),
    .A(a_s[3]), .B(b_s[3]), .out_valid(ov_s[3]),
    .out_ready(or_s[3]), .P(p3), .busy(bz_s[3]));

  function automatic logic [63:0] pget(input int d);
    case (d)
      0:       return 64'(p0);
      1:       return 64'(p1);
      2:       return 64'(p2);
      default: return p3;
    endcase
  endfunction

  function automatic int wid(input int d);
    case (d)
      0, 1:    return 8;
      2:       return 16;
      default: return 32;
    endcase
  endfunction

  function automatic bit et(input int d);
    return (d == 1) || (d == 3);
  endfunction

  function automatic logic [31:0] mask(input int d);
    logic [32:0] m;
    m = (33'd1 << wid(d)) - 33'd1;
    return m[31:0];
  endfunction

  // Edges after the accept edge until out_valid is visible.
  function automatic int exp_lat(input int d, input logic [31:0] b);
    int n;
    int h;
    n = wid(d) / 2;
    if (!et(d)) return n;
    h = -1;
    for (int i = 0; i < n; i++) begin
      if (((b >> (2 * i)) & 32'd3) != 32'd0) h = i;
    end
    return (h + 1 < 1) ? 1 : h + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete operation on instance d, with pre idle cycles before the
  // request and hold cycles of consumer back-pressure after completion.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input int pre, input int hold,
                        output logic [63:0] p, output int lat);
    repeat (pre) tick();
    chk("in_ready_idle", 64'(ir_s[d]), 64'd1);
    iv_s[d] = 1'b1;
    a_s[d]  = a;
    b_s[d]  = b;
    tick();
    iv_s[d] = 1'b0;
    a_s[d]  = $urandom;
    b_s[d]  = $urandom;
    chk("run_flags", {62'd0, ir_s[d], bz_s[d]}, 64'b01);
    lat = 0;
    while (!ov_s[d] && lat < 100) begin
      tick();
      lat++;
    end
    if (!ov_s[d]) chk("timeout", 64'd0, 64'd1);
    p = pget(d);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_flags", {61'd0, ov_s[d], ir_s[d], bz_s[d]}, 64'b101);
      chk("hold_p", pget(d), p);
    end
    or_s[d] = 1'b1;
    tick();
    or_s[d] = 1'b0;
    chk("handshake", {61'd0, ov_s[d], ir_s[d], bz_s[d]}, 64'b010);
    chk("p_kept", pget(d), p);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
    int          lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [63:0] p;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;

    vecs[0]  = '{0, 32'd255, 32'd255, 64'd65025, 4};
    vecs[1]  = '{0, 32'd0,   32'd173, 64'd0,     4};
    vecs[2]  = '{0, 32'd173, 32'd0,   64'd0,     4};
    vecs[3]  = '{0, 32'd13,  32'd11,  64'd143,   4};
    vecs[4]  = '{1, 32'd255, 32'd3,   64'd765,   1};
    vecs[5]  = '{1, 32'd10,  32'h30,  64'd480,   3};
    vecs[6]  = '{1, 32'd7,   32'hC0,  64'd1344,  4};
    vecs[7]  = '{1, 32'd99,  32'd0,   64'd0,     1};
    vecs[8]  = '{2, 32'hFFFF, 32'hFFFF, 64'd4294836225, 8};
    vecs[9]  = '{3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 16};
    vecs[10] = '{3, 32'd12345, 32'd2, 64'd24690, 1};

    for (int d = 0; d < 4; d++) begin
      iv_s[d] = 1'b0;
      or_s[d] = 1'b0;
      a_s[d]  = '0;
      b_s[d]  = '0;
    end

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      chk("reset_flags", {61'd0, ov_s[d], ir_s[d], bz_s[d]}, 64'b010);
      chk("reset_p", pget(d), 64'd0);
    end
    rst = 1'b0;
    tick();

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, 0, 0, p, lat);
      chk($sformatf("vec%0d_p", i), p, vecs[i].p);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure: result held for 6 cycles
    run_op(0, 32'd200, 32'd3, 0, 6, p, lat);
    chk("bp_p", p, 64'd600);

    // Reset during the second RUN cycle discards the operation
    iv_s[0] = 1'b1;
    a_s[0]  = 32'd100;
    b_s[0]  = 32'd100;
    tick();
    iv_s[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags", {61'd0, ov_s[0], ir_s[0], bz_s[0]}, 64'b010);
    chk("abort_p", pget(0), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_out", 64'(ov_s[0]), 64'd0);
    end
    run_op(0, 32'd7, 32'd9, 0, 0, p, lat);
    chk("after_abort_p", p, 64'd63);

    // Randomised operands and stalls against the arithmetic model
    for (int n = 0; n < 200; n++) begin
      int d;
      d = n % 4;
      a = $urandom & mask(d);
      b = ($urandom >> $urandom_range(0, 31)) & mask(d);
      run_op(d, a, b, $urandom_range(0, 2), $urandom_range(0, 3), p, lat);
      chk($sformatf("rand%0d_p", n), p, 64'(a) * 64'(b));
      chk($sformatf("rand%0d_lat", n), 64'(lat), 64'(exp_lat(d, b)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
